// File: rtl/pulse_sync_pkg.sv
// Shared types and constants for the pulse-synchronizer path
// (count pulser on the sending side, pulse accumulator on the receiving side).
package pulse_sync_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        PEND
    } acc_state_t;

    localparam int MIN_GAP_CYCLES = 2;

endpackage

// File: rtl/pulse_accumulator.sv
// Turns a train of single-cycle pulses back into per-burst counts on a
// valid/ready output, holding one pending burst under backpressure.
module pulse_accumulator
    import pulse_sync_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_count,
    output logic             out_sat,
    output logic             overrun,
    output logic             busy
);

    localparam int               GAP_W    = $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WIDTH-1:0] ACC_MAX  = '1;

    // A 1-cycle low between pulses must never split a burst.
    if (GAP_CYCLES < MIN_GAP_CYCLES) begin : g_gap_check
        $error("pulse_accumulator: GAP_CYCLES must be >= MIN_GAP_CYCLES");
    end

    acc_state_t       state, state_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [GAP_W-1:0] gap, gap_next;
    logic             sat, sat_next;
    logic             slot_free;
    logic             load_out;
    logic             drop;

    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            gap   <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            gap   <= gap_next;
            sat   <= sat_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        gap_next   = gap;
        sat_next   = sat;
        load_out   = 1'b0;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (pulse) begin
                    acc_next   = WIDTH'(1);
                    gap_next   = '0;
                    sat_next   = 1'b0;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (pulse) begin
                    if (acc == ACC_MAX) sat_next = 1'b1;
                    else                acc_next = acc + 1'b1;
                    gap_next = '0;
                end else if (gap != GAP_LAST) begin
                    gap_next = gap + 1'b1;
                end else if (slot_free) begin
                    load_out   = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (slot_free) begin
                    load_out = 1'b1;
                    if (pulse) begin
                        acc_next   = WIDTH'(1);
                        gap_next   = '0;
                        sat_next   = 1'b0;
                        state_next = COUNT;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (pulse) begin
                    drop = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output slot: a new load on the same edge as a transfer keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_sat   <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (load_out) begin
                out_valid <= 1'b1;
                out_count <= acc;
                out_sat   <= sat;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop) overrun <= 1'b1;
            busy <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_accumulator.sv
// Directed and randomized checks of pulse_accumulator against a burst-level
// model built from completed-burst queues rather than FSM states.
module tb_pulse_accumulator;

    localparam int G = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pulse;
    logic        out_ready;
    logic        out_valid, out_sat, overrun, busy;
    logic [31:0] out_count;
    logic        out_valid4, out_sat4, overrun4, busy4;
    logic [3:0]  out_count4;

    pulse_accumulator #(.WIDTH(32), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .pulse(pulse),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_sat(out_sat), .overrun(overrun), .busy(busy)
    );

    pulse_accumulator #(.WIDTH(4), .GAP_CYCLES(G)) dut4 (
        .clk(clk), .rst(rst), .pulse(pulse),
        .out_valid(out_valid4), .out_ready(out_ready), .out_count(out_count4),
        .out_sat(out_sat4), .overrun(overrun4), .busy(busy4)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Model: results waiting to be taken (head is on the output), plus the burst being counted.
    longint held[$];
    bit     act;
    longint cnt;
    int     idle;
    bit     m_ovr;
    int     dropped;

    int seen[$];
    int seen_cyc[$];
    int seen4_cnt[$];
    int seen4_sat[$];
    int first_valid, nvalid, busy_fall;
    logic prev_busy;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step(input logic p, input logic r, input logic rs);
        if (rs) begin
            held.delete();
            act   = 1'b0;
            cnt   = 0;
            idle  = 0;
            m_ovr = 1'b0;
            return;
        end
        if (held.size() > 0 && r) void'(held.pop_front());
        if (held.size() == 2) begin
            if (p) begin
                dropped++;
                m_ovr = 1'b1;
            end
        end else if (act) begin
            if (p) begin
                cnt++;
                idle = 0;
            end else begin
                idle++;
                if (idle == G) begin
                    held.push_back(cnt);
                    act = 1'b0;
                end
            end
        end else if (p) begin
            act  = 1'b1;
            cnt  = 1;
            idle = 0;
        end
    endtask

    task automatic apply_stimulus(input logic p, input logic r, input logic rs);
        @(negedge clk);
        pulse     = p;
        out_ready = r;
        rst       = rs;
        check_output("valid", out_valid, held.size() > 0);
        if (held.size() > 0) begin
            check_output("count", out_count, held[0]);
            check_output("sat", out_sat, 0);
        end
        check_output("overrun", overrun, m_ovr);
        check_output("busy", busy, act || held.size() == 2);
        if (out_valid && r) begin
            seen.push_back(int'(out_count));
            seen_cyc.push_back(cyc);
        end
        if (out_valid4 && r) begin
            seen4_cnt.push_back(int'(out_count4));
            seen4_sat.push_back(int'(out_sat4));
        end
        if (out_valid) begin
            nvalid++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (prev_busy && !busy && busy_fall < 0) busy_fall = cyc;
        prev_busy = busy;
        model_step(p, r, rs);
        cyc++;
    endtask

    task automatic run_pulses(input int n, input logic r);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, r, 1'b0);
    endtask

    task automatic run_idle(input int n, input logic r);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, r, 1'b0);
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        int driven, sum, drop_base, len;
        bit hold_low;

        rst         = 1'b1;
        pulse       = 1'b0;
        out_ready   = 1'b0;
        act         = 1'b0;
        cnt         = 0;
        idle        = 0;
        m_ovr       = 1'b0;
        dropped     = 0;
        first_valid = -1;
        busy_fall   = -1;
        nvalid      = 0;
        prev_busy   = 1'b0;
        repeat (2) @(posedge clk);

        // Burst 1,0,1,0,1 from cycle 10: single result of 3 visible in cycle 19 only
        run_idle(10, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        run_idle(10, 1'b1);
        check_output("t1_first_valid", first_valid, 19);
        check_output("t1_valid_cycles", nvalid, 1);
        check_output("t1_busy_fall", busy_fall, 19);
        check_output("t1_count", at(seen, 0), 3);

        // Gap of G-1 idles merges bursts; a gap of G splits them
        seen.delete();
        run_pulses(2, 1'b1); run_idle(3, 1'b1); run_pulses(5, 1'b1); run_idle(8, 1'b1);
        check_output("t2_merge_n", seen.size(), 1);
        check_output("t2_merge_v", at(seen, 0), 7);
        seen.delete();
        run_pulses(2, 1'b1); run_idle(4, 1'b1); run_pulses(5, 1'b1); run_idle(8, 1'b1);
        check_output("t2_split_n", seen.size(), 2);
        check_output("t2_split_a", at(seen, 0), 2);
        check_output("t2_split_b", at(seen, 1), 5);

        // Backpressure: hold 2, pend 3, drop one pulse, then drain back-to-back
        seen.delete();
        seen_cyc.delete();
        run_pulses(2, 1'b0); run_idle(6, 1'b0);
        run_pulses(3, 1'b0); run_idle(6, 1'b0);
        run_pulses(1, 1'b0); run_idle(1, 1'b0);
        check_output("t3_overrun_set", overrun, 1);
        run_idle(4, 1'b1);
        check_output("t3_n", seen.size(), 2);
        check_output("t3_a", at(seen, 0), 2);
        check_output("t3_b", at(seen, 1), 3);
        check_output("t3_consecutive", at(seen_cyc, 1) - at(seen_cyc, 0), 1);
        check_output("t3_overrun_sticky", overrun, 1);

        // Saturation in the 4-bit instance, cleared by the following burst
        seen4_cnt.delete();
        seen4_sat.delete();
        run_pulses(20, 1'b1); run_idle(6, 1'b1);
        run_pulses(2, 1'b1);  run_idle(6, 1'b1);
        check_output("t4_n", seen4_cnt.size(), 2);
        check_output("t4_sat_count", at(seen4_cnt, 0), 15);
        check_output("t4_sat_flag", at(seen4_sat, 0), 1);
        check_output("t4_next_count", at(seen4_cnt, 1), 2);
        check_output("t4_next_flag", at(seen4_sat, 1), 0);

        // Reset in the middle of a burst discards it and clears overrun
        seen.delete();
        run_pulses(3, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output("t5_rst_valid", out_valid, 0);
        check_output("t5_rst_count", out_count, 0);
        check_output("t5_rst_overrun", overrun, 0);
        check_output("t5_rst_busy", busy, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        run_idle(6, 1'b1);
        check_output("t5_n", seen.size(), 1);
        check_output("t5_count", at(seen, 0), 2);
        check_output("t5_overrun", overrun, 0);

        // Random bursts under random backpressure: pulses are conserved
        seen.delete();
        driven    = 0;
        drop_base = dropped;
        for (int b = 0; b < 100; b++) begin
            len      = $urandom_range(1, 8);
            hold_low = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < len; i++) begin
                apply_stimulus(1'b1, hold_low ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
                driven++;
                if (i < len - 1 && $urandom_range(0, 3) == 0)
                    apply_stimulus(1'b0, hold_low ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
            end
            for (int i = 0; i < int'($urandom_range(0, 8)); i++)
                apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        run_idle(12, 1'b1);
        sum = 0;
        foreach (seen[i]) sum += seen[i];
        check_output("rand_conservation", sum + (dropped - drop_base), driven);
        check_output("rand_drained_valid", out_valid, 0);
        check_output("rand_drained_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pulse_accumulator.md
# pulse_accumulator

Counts single-cycle pulses on one input line, groups them into bursts separated by a programmable idle gap, and presents each burst's total on a valid/ready output. It sits directly downstream of the count pulser in the pulse-synchronizer path and turns its pulse train back into a count, so the pair can be checked end to end. Backpressure is absorbed by one pending burst; pulses beyond that are dropped and flagged.

## Interface
Parameters:
- `WIDTH`, default 32: width of the burst count and of `out_count`.
- `GAP_CYCLES`, default 4: number of consecutive pulse-free cycles that ends a burst. Legal range is at least 2, so a 1-cycle LOW between pulses never splits a burst.

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `pulse`, input, 1: pulse stream. Each cycle it is high counts as one pulse.
- `out_valid`, output, 1: burst result is available.
- `out_ready`, input, 1: consumer accepts the result.
- `out_count`, output, WIDTH: pulse total of the burst.
- `out_sat`, output, 1: the burst total saturated.
- `overrun`, output, 1: sticky flag; a pulse was dropped.
- `busy`, output, 1: the accumulator is not IDLE.

## Operation
- Outputs during and after reset: `out_valid`=0, `out_count`=0, `out_sat`=0, `overrun`=0, `busy`=0. Internal state: accumulator=0, gap=0, state IDLE.
- States:
  - IDLE
    - `pulse`=1: load acc=1 and gap=0, then go to COUNT.
  - COUNT
    - `pulse`=1: acc increments and saturates at 2^WIDTH-1; the per-burst sat bit is set if an increment was attempted at max; gap returns to 0.
    - `pulse`=0 with gap < GAP_CYCLES-1: gap increments.
    - `pulse`=0 with gap == GAP_CYCLES-1: the burst ends.
      - Output slot free (`out_valid`=0, or `out_valid`&&`out_ready` this cycle): load `out_count`/`out_sat` and go to IDLE.
      - Otherwise: go to PEND.
  - PEND (acc is held)
    - Output slot frees: transfer acc to the output. If `pulse`=1 in that same cycle, go to COUNT with acc=1; otherwise go to IDLE.
    - Otherwise: any `pulse`=1 is dropped and sets `overrun`.
- Output handshake:
  - A transfer occurs on `out_valid`&&`out_ready`.
  - `out_count`/`out_sat` stay stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` drops the cycle after a transfer unless a new result is loaded on the same edge.
- `overrun` clears only on `rst`.
- `busy` is 1 in COUNT and PEND.
- `rst` asserted mid-burst or in PEND: the partial and pending counts are discarded and the block returns to reset values on the next edge.

## Timing
- Last pulse of a burst is high in cycle L, with `pulse` low in cycles L+1 to L+GAP_CYCLES. Then `out_valid`=1 from cycle L+GAP_CYCLES+1, provided the slot is free.
- A pulse arriving after exactly GAP_CYCLES-1 idle cycles continues the same burst.
- Throughput is one result per cycle at most. The back-to-back minimum burst spacing is GAP_CYCLES+1 cycles.
- A PEND→output transfer lands `out_valid` the cycle after the slot frees, with zero bubble when `out_ready` is held high.
- All outputs are registered. There is no combinational path from `pulse` or `out_ready` to any output.

## Structure
- Shared package `pulse_sync_pkg` holds:
  - the enum type `acc_state_t` {IDLE, COUNT, PEND};
  - the constant `MIN_GAP_CYCLES = 2`.
- Single module with no sub-module. The output register is a few lines and stays inline.
- Elaboration-time assertion: GAP_CYCLES ≥ MIN_GAP_CYCLES.

## Test plan
- GAP_CYCLES=4, `out_ready`=1. Pulse pattern 1,0,1,0,1 starting cycle 10, then idle. Required: `out_count`=3 and `out_valid`=1 in cycle 19 only; `busy` falls in cycle 19.
- Two bursts of 2 and 5 pulses separated by exactly 3 idle cycles. Required: one result, `out_count`=7. Repeat with 4 idle cycles. Required: two results, 2 then 5.
- `out_ready`=0. Burst of 2 completes (output holds 2), burst of 3 completes (PEND), then 1 extra pulse. Required: `overrun`=1. Then raise `out_ready`. Required: results 2 then 3 on consecutive cycles; `overrun` stays 1.
- WIDTH=4 with 20 consecutive pulses, then idle. Required: `out_count`=15, `out_sat`=1. A following 2-pulse burst gives `out_sat`=0.
- Assert `rst` for one cycle in the middle of a 6-pulse burst, then send 2 pulses. Required: outputs at reset values the cycle after `rst`; the next result is `out_count`=2; `overrun`=0.
- Random `out_ready` with 100 random bursts. Required: the scoreboard sums of `out_count` plus dropped pulses equal the pulses driven, with no transfer lost or duplicated.
